tdm_demux: RTL
==============

# tdm_demux

Time-division demultiplexer: the receive end of the team's mux-based serial channel sharing. It accepts one shared data stream carrying CHANNELS time slots per frame, with a frame-sync marker on slot 0. It routes each valid beat to its channel's output register and flags frame completion and sync errors. It sits downstream of a TDM multiplexer (select-driven mux plus slot counter) and feeds per-channel consumers.

## Interface
- CHANNELS, 4, slots per frame; power of two, 2..16
- DATA_W, 8, bits per slot sample
- clk_in  input  1  single clock, all logic on rising edge
- rst_in  input  1  asynchronous, active-high reset
- data_in  input  DATA_W  shared TDM sample
- valid_in  input  1  data_in carries a slot sample this cycle
- sync_in  input  1  qualified by valid_in; marks slot 0 of a frame
- clr_err_in  input  1  clears sync_err_out
- ch_data_out  output  CHANNELS*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]; holds last sample
- ch_valid_out  output  CHANNELS  one-cycle pulse per channel on update
- frame_done_out  output  1  one-cycle pulse when slot CHANNELS-1 is written
- locked_out  output  1  high in LOCKED state
- sync_err_out  output  1  sticky sync-error flag
- frame_cnt_out  output  16  completed frames, wraps 0xFFFF→0

## Operation
- States: HUNT, LOCKED. Reset state is HUNT.
- HUNT:
  - Beats without sync_in are discarded; no outputs change.
  - A beat with valid_in&sync_in writes channel 0, sets slot=1 and enters LOCKED.
- LOCKED, valid beat, expected slot s:
  - sync_in=0 and s≠0: write channel s; slot=s+1 mod CHANNELS.
  - sync_in=1 and s=0: normal frame start; write channel 0; slot=1.
  - sync_in=1 and s≠0 (early sync): set sync_err; treat the beat as slot 0 (write channel 0, slot=1); stay LOCKED. The partial frame gives no frame_done and no frame_cnt increment.
  - sync_in=0 and s=0 (missing sync): set sync_err; discard the beat; go to HUNT.
- Writing slot CHANNELS-1 pulses frame_done_out and increments frame_cnt_out (wraps).
- valid_in=0: nothing happens. sync_in is ignored when valid_in=0.
- clr_err_in:
  - Clears sync_err_out next cycle.
  - If an error occurs in the same cycle as clr_err_in, the set wins.
- Slot counter width is clog2(CHANNELS). Wrap is modulo CHANNELS.

## Timing
- All outputs are registered. Latency is 1 cycle from the valid beat to ch_data_out, ch_valid_out, frame_done_out, frame_cnt_out and locked_out.
- Full throughput: one sample per cycle, no backpressure. valid_in may be high every cycle.
- Reset values:
  - ch_data_out = 0, ch_valid_out = 0, frame_done_out = 0
  - locked_out = 0, sync_err_out = 0, frame_cnt_out = 0
  - slot = 0, state HUNT
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronous). After release, a sync beat is required to lock.
- At most one ch_valid_out bit is high in any cycle.
- frame_done_out coincides with ch_valid_out[CHANNELS-1].
- locked_out drops the cycle after a missing-sync beat. sync_err_out rises in that same cycle.

## Structure
- Package tdm_pkg holds:
  - state enum {HUNT, LOCKED}
  - FRAME_CNT_W = 16
  - slot-width function clog2 shared with the TDM mux transmitter
- Sub-module tdm_slot_ctr: parameterized modulo-CHANNELS counter.
  - Inputs: load-to-1 and increment.
  - Output: current slot.
  - Reusable by the transmit side.
- Top level contains the FSM, channel register bank, error flag and frame counter.

## Test plan
- CHANNELS=4. Reset, then the frame 0x11(sync),0x22,0x33,0x44 on consecutive cycles:
  - ch_valid_out pulses 0001,0010,0100,1000
  - ch_data_out = 0x44332211
  - frame_done_out pulses once; frame_cnt_out = 1; locked_out = 1
- Beats 0xAA,0xBB with no sync before the first sync beat:
  - outputs unchanged; locked_out stays 0
  - subsequent sync frame decodes correctly
- Early sync: sync on 0x55 at slot 2 after writing slots 0–1:
  - sync_err_out = 1; channel 0 = 0x55; no frame_done; frame_cnt_out unchanged
  - next three beats complete the frame; frame_cnt_out increments
- Missing sync: a 5th beat arrives without sync:
  - sync_err_out = 1; locked_out = 0; beat discarded
  - clr_err_in pulse → sync_err_out = 0 next cycle
- rst_in asserted mid-frame (after slot 1): all outputs read 0 immediately; a fresh frame after release decodes to 0x44332211.
- valid_in gapped (1 beat every 3 cycles) across 0x10000 frames: frame_cnt_out wraps to 0 with no errors.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Purpose  : Shared definitions for the TDM channel-sharing link: receiver
//             state encoding, frame-counter width and the slot-width helper
//             also used by the transmit-side multiplexer.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

   // Receiver framing state.
   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

   localparam int FRAME_CNT_W = 16;

   // Bits needed to number n slots; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_ctr
//  Purpose  : Modulo-CHANNELS slot counter. A load forces the count to 1
//             (the slot that follows a sync beat); an increment advances it
//             with wrap to 0 after CHANNELS-1. Load has priority.
//  Ports    : clk_in      - clock
//             rst_in      - asynchronous active-high reset (count -> 0)
//             load1_in    - load the value 1
//             inc_in      - advance by one slot
//             slot_out    - current slot number
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SLOT_W   = clog2(CHANNELS)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              load1_in,
   input  logic              inc_in,
   output logic [SLOT_W-1:0] slot_out
);

   localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(CHANNELS - 1);

   logic [SLOT_W-1:0] slot_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         slot_q <= '0;
      end else if (load1_in) begin
         slot_q <= SLOT_W'(1);
      end else if (inc_in) begin
         slot_q <= (slot_q == c_LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
      end
   end

   assign slot_out = slot_q;

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Purpose  : Receive end of the TDM channel-sharing link. Hunts for the
//             slot-0 sync marker, then routes each valid beat to its
//             channel register, pulses frame completion, counts frames and
//             keeps a sticky sync-error flag.
//  Ports    : clk_in         - clock, rising edge
//             rst_in         - asynchronous active-high reset
//             data_in        - shared TDM sample
//             valid_in       - data_in carries a slot sample
//             sync_in        - slot-0 marker (qualified by valid_in)
//             clr_err_in     - clear sync_err_out
//             ch_data_out    - channel k at [k*DATA_W +: DATA_W], holds value
//             ch_valid_out   - one-cycle update pulse per channel
//             frame_done_out - pulse when the last slot is written
//             locked_out     - receiver is in LOCKED
//             sync_err_out   - sticky sync-error flag
//             frame_cnt_out  - completed frames, wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       valid_in,
   input  logic                       sync_in,
   input  logic                       clr_err_in,
   output logic [CHANNELS*DATA_W-1:0] ch_data_out,
   output logic [CHANNELS-1:0]        ch_valid_out,
   output logic                       frame_done_out,
   output logic                       locked_out,
   output logic                       sync_err_out,
   output logic [FRAME_CNT_W-1:0]     frame_cnt_out
);

   localparam int                c_SLOT_W    = clog2(CHANNELS);
   localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(CHANNELS - 1);

   tdm_state_t                  state_q, state_d;
   logic [CHANNELS*DATA_W-1:0]  ch_data_q;
   logic [CHANNELS-1:0]         ch_valid_q;
   logic                        frame_done_q;
   logic                        locked_q;
   logic                        sync_err_q;
   logic [FRAME_CNT_W-1:0]      frame_cnt_q;

   logic [c_SLOT_W-1:0]         w_slot;
   logic [CHANNELS-1:0]         wr_sel_d;
   logic                        w_load1;
   logic                        w_inc;
   logic                        w_err_set;
   logic                        w_frame_end;

   tdm_slot_ctr #(
      .CHANNELS (CHANNELS),
      .SLOT_W   (c_SLOT_W)
   ) u_slot_ctr (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .load1_in (w_load1),
      .inc_in   (w_inc),
      .slot_out (w_slot)
   );

   // Beat classification. A sync beat always restarts the frame at slot 0,
   // even when it arrives early; a missing sync drops lock instead.
   always_comb begin
      state_d     = state_q;
      wr_sel_d    = '0;
      w_load1     = 1'b0;
      w_inc       = 1'b0;
      w_err_set   = 1'b0;
      w_frame_end = 1'b0;
      if (valid_in) begin
         case (state_q)
            HUNT: begin
               if (sync_in) begin
                  wr_sel_d[0] = 1'b1;
                  w_load1     = 1'b1;
                  state_d     = LOCKED;
               end
            end
            default: begin
               if (sync_in) begin
                  w_err_set   = (w_slot != '0);
                  wr_sel_d[0] = 1'b1;
                  w_load1     = 1'b1;
               end else if (w_slot == '0) begin
                  w_err_set = 1'b1;
                  state_d   = HUNT;
               end else begin
                  wr_sel_d[w_slot] = 1'b1;
                  w_inc            = 1'b1;
                  // Slot 0 is only ever written on the sync path, so the
                  // last slot can only complete a frame here.
                  w_frame_end      = (w_slot == c_LAST_SLOT);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= HUNT;
         ch_data_q    <= '0;
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         locked_q     <= (state_d == LOCKED);
         ch_valid_q   <= wr_sel_d;
         frame_done_q <= w_frame_end;
         for (int k = 0; k < CHANNELS; k++) begin
            if (wr_sel_d[k]) begin
               ch_data_q[k*DATA_W +: DATA_W] <= data_in;
            end
         end
         if (w_frame_end) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
         end
         // A new error outranks a simultaneous clear.
         if (w_err_set) begin
            sync_err_q <= 1'b1;
         end else if (clr_err_in) begin
            sync_err_q <= 1'b0;
         end
      end
   end

   assign ch_data_out    = ch_data_q;
   assign ch_valid_out   = ch_valid_q;
   assign frame_done_out = frame_done_q;
   assign locked_out     = locked_q;
   assign sync_err_out   = sync_err_q;
   assign frame_cnt_out  = frame_cnt_q;

endmodule
`default_nettype wire
